// File: rtl/ntt_pair_loader_if.sv
// Pair stream in, FIFO source port out, for the NTT pair loader.
// The master drives pairs, length and full; the slave is the loader.
interface ntt_pair_loader_if #(
  parameter int BIT_WIDTH = 16,
  parameter int LINE_SIZE = 4,
  parameter int MAX_LEN   = 64
);
  localparam int AW   = $clog2(MAX_LEN / LINE_SIZE);
  localparam int LENW = $clog2(MAX_LEN) + 1;

  logic [LENW-1:0]                length;
  logic                           in_valid;
  logic                           in_ready;
  logic [BIT_WIDTH-1:0]           in_dA;
  logic [BIT_WIDTH-1:0]           in_dB;
  logic                           in_last;
  logic                           fifo_full;
  logic [AW-1:0]                  fifo_addrA;
  logic [AW-1:0]                  fifo_addrB;
  logic [BIT_WIDTH*LINE_SIZE-1:0] fifo_dA;
  logic [BIT_WIDTH*LINE_SIZE-1:0] fifo_dB;
  logic [LINE_SIZE-1:0]           word_selA;
  logic [LINE_SIZE-1:0]           word_selB;
  logic                           wr_finish;
  logic                           err_last;

  modport master (
    output length, in_valid, in_dA, in_dB,
    output in_last, fifo_full,
    input  in_ready, fifo_addrA, fifo_addrB,
    input  fifo_dA, fifo_dB, word_selA,
    input  word_selB, wr_finish, err_last
  );

  modport slave (
    input  length, in_valid, in_dA, in_dB,
    input  in_last, fifo_full,
    output in_ready, fifo_addrA, fifo_addrB,
    output fifo_dA, fifo_dB, word_selA,
    output word_selB, wr_finish, err_last
  );
endinterface

// File: rtl/ntt_pair_loader.sv
// Packs butterfly pairs into A/B FIFO lines and flips the
// ping-pong buffer after the last pair of each polynomial.
module ntt_pair_loader #(
  parameter int BIT_WIDTH = 16,
  parameter int LINE_SIZE = 4,
  parameter int MAX_LEN   = 64
) (
  input logic              clk,
  input logic              rstn,
  ntt_pair_loader_if.slave bus
);
  localparam int AW = $clog2(MAX_LEN / LINE_SIZE);
  localparam int KW = $clog2(MAX_LEN);
  localparam int LW = $clog2(LINE_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_e;

  typedef logic [LINE_SIZE-1:0][BIT_WIDTH-1:0] line_t;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [KW:0]          len_q, len_d;
  line_t                latch_a_q, latch_a_d;
  line_t                latch_b_q, latch_b_d;
  logic                 in_ready_q, in_ready_d;
  logic [AW-1:0]        addr_a_q, addr_a_d;
  logic [AW-1:0]        addr_b_q, addr_b_d;
  line_t                d_a_q, d_a_d;
  line_t                d_b_q, d_b_d;
  logic [LINE_SIZE-1:0] sel_a_q, sel_a_d;
  logic [LINE_SIZE-1:0] sel_b_q, sel_b_d;
  logic                 wr_finish_q, wr_finish_d;
  logic                 err_q, err_d;

  logic [KW:0]   len_eff;
  logic [KW:0]   half;
  logic [AW-1:0] base_b;
  logic [LW-1:0] word;
  logic          acc;
  logic          is_last;
  logic          line_end;
  line_t         line_a;
  line_t         line_b;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    len_d       = len_q;
    latch_a_d   = latch_a_q;
    latch_b_d   = latch_b_q;
    in_ready_d  = 1'b0;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    d_a_d       = d_a_q;
    d_b_d       = d_b_q;
    sel_a_d     = '0;
    sel_b_d     = '0;
    wr_finish_d = wr_finish_q;
    err_d       = err_q;

    // The length port is only honoured while idle.
    len_eff  = (state_q == IDLE) ? bus.length : len_q;
    half     = len_eff >> 1;
    base_b   = len_eff[KW:LW+1];
    word     = k_q[LW-1:0];
    acc      = bus.in_valid & in_ready_q;
    is_last  = ({1'b0, k_q} == half - 1'b1);
    line_end = (word == LW'(LINE_SIZE - 1));

    line_a       = latch_a_q;
    line_b       = latch_b_q;
    line_a[word] = bus.in_dA;
    line_b[word] = bus.in_dB;

    unique case (state_q)
      IDLE: begin
        len_d = bus.length;
        if (acc) state_d = FILL;
      end
      FILL: begin
        if (acc && is_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (acc) begin
      latch_a_d = line_a;
      latch_b_d = line_b;
      k_d       = k_q + 1'b1;
      if (bus.in_last != is_last) err_d = 1'b1;
      if (line_end) begin
        d_a_d    = line_a;
        d_b_d    = line_b;
        sel_a_d  = '1;
        sel_b_d  = '1;
        addr_a_d = k_q[KW-1:LW];
        addr_b_d = base_b + k_q[KW-1:LW];
      end
    end

    if (state_q == DONE) k_d = '0;

    // Full is re-checked for one idle cycle before accepting again.
    unique case (state_d)
      IDLE:    in_ready_d = (state_q == IDLE) & ~bus.fifo_full;
      FILL:    in_ready_d = 1'b1;
      default: in_ready_d = 1'b0;
    endcase

    wr_finish_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      k_q         <= '0;
      len_q       <= '0;
      latch_a_q   <= '0;
      latch_b_q   <= '0;
      in_ready_q  <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      d_a_q       <= '0;
      d_b_q       <= '0;
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      wr_finish_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      len_q       <= len_d;
      latch_a_q   <= latch_a_d;
      latch_b_q   <= latch_b_d;
      in_ready_q  <= in_ready_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      d_a_q       <= d_a_d;
      d_b_q       <= d_b_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      wr_finish_q <= wr_finish_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.fifo_addrA = addr_a_q;
  assign bus.fifo_addrB = addr_b_q;
  assign bus.fifo_dA    = d_a_q;
  assign bus.fifo_dB    = d_b_q;
  assign bus.word_selA  = sel_a_q;
  assign bus.word_selB  = sel_b_q;
  assign bus.wr_finish  = wr_finish_q;
  assign bus.err_last   = err_q;
endmodule

// File: tb/tb_ntt_pair_loader.sv
// Randomised bench for ntt_pair_loader: a line-level model of the
// expected FIFO writes is compared against captured write traffic.
module tb_ntt_pair_loader;
  localparam int BW = 16;
  localparam int L  = 4;
  localparam int ML = 64;
  localparam int AW = $clog2(ML / L);

  typedef struct {
    int              cyc;
    logic [AW-1:0]   a;
    logic [AW-1:0]   b;
    logic [L*BW-1:0] da;
    logic [L*BW-1:0] db;
    logic [L-1:0]    sa;
    logic [L-1:0]    sb;
  } wr_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   checks;
  int   fails;

  ntt_pair_loader_if #(.BIT_WIDTH(BW), .LINE_SIZE(L), .MAX_LEN(ML)) bus ();

  ntt_pair_loader #(
    .BIT_WIDTH(BW),
    .LINE_SIZE(L),
    .MAX_LEN(ML)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wr_t  wq[$];
  wr_t  exp_q[$];
  int   acc_cyc[$];
  int   rise_cyc[$];
  int   pa[$];
  int   pb[$];
  logic wf_prev;

  always @(negedge clk) begin
    if (!rstn) begin
      wf_prev = bus.wr_finish;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
      if (bus.word_selA != 0 || bus.word_selB != 0) begin
        wr_t w;
        w.cyc = cyc;
        w.a   = bus.fifo_addrA;
        w.b   = bus.fifo_addrB;
        w.da  = bus.fifo_dA;
        w.db  = bus.fifo_dB;
        w.sa  = bus.word_selA;
        w.sb  = bus.word_selB;
        wq.push_back(w);
      end
      if (bus.wr_finish && !wf_prev) rise_cyc.push_back(cyc);
      wf_prev = bus.wr_finish;
    end
  end

  task automatic clear_logs();
    wq.delete();
    exp_q.delete();
    acc_cyc.delete();
    rise_cyc.delete();
  endtask

  task automatic gen(input int len, input bit ramp);
    pa.delete();
    pb.delete();
    for (int k = 0; k < len / 2; k++) begin
      pa.push_back(ramp ? k : int'($urandom & 16'hffff));
      pb.push_back(ramp ? 100 + k : int'($urandom & 16'hffff));
    end
  endtask

  // Expected writes: line j of the lower half goes to A[j], the same
  // line of the upper half to B[len/(2L)+j].
  task automatic model(input int len);
    int nl;
    nl = len / (2 * L);
    for (int j = 0; j < nl; j++) begin
      wr_t e;
      e.cyc = 0;
      e.a   = AW'(j);
      e.b   = AW'(nl + j);
      e.da  = '0;
      e.db  = '0;
      for (int w = 0; w < L; w++) begin
        e.da[w*BW +: BW] = BW'(pa[j*L + w]);
        e.db[w*BW +: BW] = BW'(pb[j*L + w]);
      end
      e.sa = '1;
      e.sb = '1;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input int k, input bit last, input bit gap);
    bit got;
    int t;
    got = 0;
    t   = 0;
    bus.in_valid = 1'b1;
    bus.in_dA    = BW'(pa[k]);
    bus.in_dB    = BW'(pb[k]);
    bus.in_last  = last;
    while (!got && t < 100) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: pair k=%0d not accepted in %0d cycles", k, t);
    end
    if (gap) step(1);
  endtask

  task automatic send_poly(input int len, input bit gap, input int lastk, input int newlen);
    for (int k = 0; k < len / 2; k++) begin
      send_pair(k, k == lastk, gap);
      if (k == 2 && newlen != 0) bus.length = 7'(newlen);
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    bus.fifo_full = 1'b0;
    rstn = 1'b0;
    step(2);
    checks++;
    if ({bus.in_ready, bus.wr_finish, bus.err_last} !== 3'b010) begin
      fails++;
      $display("FAIL reset_ctrl: ready/wr_finish/err=%b%b%b, expected 010",
               bus.in_ready, bus.wr_finish, bus.err_last);
    end
    checks++;
    if ({bus.word_selA, bus.word_selB, bus.fifo_addrA, bus.fifo_addrB,
         bus.fifo_dA, bus.fifo_dB} !== '0) begin
      fails++;
      $display("FAIL reset_fifo: sel=%b/%b addr=%0d/%0d dA=%h dB=%h, expected all 0",
               bus.word_selA, bus.word_selB, bus.fifo_addrA, bus.fifo_addrB,
               bus.fifo_dA, bus.fifo_dB);
    end
    rstn = 1'b1;
    step(2);
  endtask

  task automatic test_basic();
    clear_logs();
    bus.length = 7'd16;
    gen(16, 1);
    model(16);
    step(1);
    send_poly(16, 0, 7, 0);
    step(4);
    checks++;
    if (wq.size() != exp_q.size()) begin
      fails++;
      $display("FAIL basic_count: %0d writes, expected %0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({wq[i].a, wq[i].b, wq[i].da, wq[i].db, wq[i].sa, wq[i].sb} !==
          {exp_q[i].a, exp_q[i].b, exp_q[i].da, exp_q[i].db, exp_q[i].sa, exp_q[i].sb}) begin
        fails++;
        $display("FAIL basic_line%0d: a=%0d b=%0d dA=%h dB=%h sel=%b/%b, expected a=%0d b=%0d dA=%h dB=%h",
                 i, wq[i].a, wq[i].b, wq[i].da, wq[i].db, wq[i].sa, wq[i].sb,
                 exp_q[i].a, exp_q[i].b, exp_q[i].da, exp_q[i].db);
      end
    end
    if (wq.size() > 1) begin
      checks++;
      if (wq[1].da !== 64'h0007_0006_0005_0004) begin
        fails++;
        $display("FAIL basic_lineA1: got %h, expected 0007000600050004", wq[1].da);
      end
      checks++;
      if (rise_cyc.size() != 1 || rise_cyc[0] != wq[1].cyc + 1) begin
        fails++;
        $display("FAIL basic_flip: %0d rises (first at %0d), expected 1 at %0d",
                 rise_cyc.size(), rise_cyc.size() ? rise_cyc[0] : -1, wq[1].cyc + 1);
      end
    end
  endtask

  task automatic test_full_stall();
    int c;
    clear_logs();
    bus.length    = 7'd16;
    bus.fifo_full = 1'b1;
    gen(16, 0);
    model(16);
    step(2);
    bus.in_valid = 1'b1;
    bus.in_dA    = BW'(pa[0]);
    bus.in_dB    = BW'(pb[0]);
    step(5);
    checks++;
    if (bus.in_ready !== 1'b0 || acc_cyc.size() != 0 || wq.size() != 0) begin
      fails++;
      $display("FAIL full_stall: ready=%b accepts=%0d writes=%0d, expected 0/0/0",
               bus.in_ready, acc_cyc.size(), wq.size());
    end
    bus.fifo_full = 1'b0;
    c = cyc;
    send_poly(16, 0, 7, 0);
    step(4);
    checks++;
    if (acc_cyc.size() == 0 || acc_cyc[0] != c + 1) begin
      fails++;
      $display("FAIL full_release: first accept at %0d, expected %0d",
               acc_cyc.size() ? acc_cyc[0] : -1, c + 1);
    end
    checks++;
    if (wq.size() != exp_q.size()) begin
      fails++;
      $display("FAIL full_count: %0d writes, expected %0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({wq[i].a, wq[i].b, wq[i].da, wq[i].db} !==
          {exp_q[i].a, exp_q[i].b, exp_q[i].da, exp_q[i].db}) begin
        fails++;
        $display("FAIL full_line%0d: a=%0d b=%0d dA=%h dB=%h, expected a=%0d b=%0d dA=%h dB=%h",
                 i, wq[i].a, wq[i].b, wq[i].da, wq[i].db,
                 exp_q[i].a, exp_q[i].b, exp_q[i].da, exp_q[i].db);
      end
    end
  endtask

  task automatic test_toggle_valid();
    clear_logs();
    bus.length = 7'd16;
    gen(16, 0);
    model(16);
    step(1);
    send_poly(16, 1, 7, 32);
    step(4);
    checks++;
    if (wq.size() != exp_q.size() || acc_cyc.size() != 8) begin
      fails++;
      $display("FAIL toggle_count: %0d writes %0d accepts, expected %0d and 8",
               wq.size(), acc_cyc.size(), exp_q.size());
    end
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({wq[i].a, wq[i].b, wq[i].da, wq[i].db} !==
          {exp_q[i].a, exp_q[i].b, exp_q[i].da, exp_q[i].db}) begin
        fails++;
        $display("FAIL toggle_line%0d: a=%0d b=%0d dA=%h dB=%h, expected a=%0d b=%0d dA=%h dB=%h",
                 i, wq[i].a, wq[i].b, wq[i].da, wq[i].db,
                 exp_q[i].a, exp_q[i].b, exp_q[i].da, exp_q[i].db);
      end
      if (acc_cyc.size() > i * L + L - 1) begin
        checks++;
        if (wq[i].cyc != acc_cyc[i*L + L - 1] + 1) begin
          fails++;
          $display("FAIL toggle_latency%0d: write at %0d, expected %0d",
                   i, wq[i].cyc, acc_cyc[i*L + L - 1] + 1);
        end
      end
    end
    checks++;
    if (rise_cyc.size() != 1) begin
      fails++;
      $display("FAIL toggle_flip: %0d rises, expected 1", rise_cyc.size());
    end
  endtask

  task automatic test_bad_last();
    clear_logs();
    bus.length = 7'd16;
    gen(16, 0);
    model(16);
    step(1);
    checks++;
    if (bus.err_last !== 1'b0) begin
      fails++;
      $display("FAIL badlast_pre: err_last=%b, expected 0", bus.err_last);
    end
    send_poly(16, 0, 3, 0);
    step(4);
    checks++;
    if (bus.err_last !== 1'b1 || acc_cyc.size() != 8 || rise_cyc.size() != 1) begin
      fails++;
      $display("FAIL badlast: err=%b accepts=%0d rises=%0d, expected 1/8/1",
               bus.err_last, acc_cyc.size(), rise_cyc.size());
    end
    checks++;
    if (wq.size() != 2 || wq[1].db !== exp_q[1].db) begin
      fails++;
      $display("FAIL badlast_data: %0d writes, expected 2 with model data", wq.size());
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    clear_logs();
    bus.length = 7'd16;
    gen(16, 0);
    for (int k = 0; k < 5; k++) send_pair(k, 0, 0);
    rstn = 1'b0;
    #2;
    checks++;
    if ({bus.in_ready, bus.wr_finish, bus.err_last, bus.word_selA, bus.word_selB,
         bus.fifo_addrA, bus.fifo_addrB, bus.fifo_dA, bus.fifo_dB} !==
        {3'b010, {(2*L + 2*AW + 2*L*BW){1'b0}}}) begin
      fails++;
      $display("FAIL resetmid_vals: ready=%b wf=%b err=%b sel=%b/%b addr=%0d/%0d",
               bus.in_ready, bus.wr_finish, bus.err_last, bus.word_selA,
               bus.word_selB, bus.fifo_addrA, bus.fifo_addrB);
    end
    step(2);
    rstn = 1'b1;
    step(2);
    checks++;
    if (rise_cyc.size() != 0) begin
      fails++;
      $display("FAIL resetmid_flip: %0d rises, expected 0", rise_cyc.size());
    end
    clear_logs();
    gen(16, 0);
    model(16);
    send_poly(16, 0, 7, 0);
    step(4);
    checks++;
    if (wq.size() != 2 || wq[0].a !== 4'd0 || wq[0].da !== exp_q[0].da) begin
      fails++;
      $display("FAIL resetmid_restart: %0d writes first addrA=%0d, expected 2 at 0",
               wq.size(), wq.size() ? wq[0].a : 4'd15);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    bus.length = 7'd8;
    gen(8, 0);
    model(8);
    step(1);
    send_poly(8, 0, 3, 0);
    bus.length = 7'd32;
    gen(32, 0);
    model(32);
    send_poly(32, 0, 15, 0);
    step(5);
    checks++;
    if (wq.size() != exp_q.size() || rise_cyc.size() != 2) begin
      fails++;
      $display("FAIL b2b_count: %0d writes %0d rises, expected %0d and 2",
               wq.size(), rise_cyc.size(), exp_q.size());
    end
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({wq[i].a, wq[i].b, wq[i].da, wq[i].db} !==
          {exp_q[i].a, exp_q[i].b, exp_q[i].da, exp_q[i].db}) begin
        fails++;
        $display("FAIL b2b_line%0d: a=%0d b=%0d dA=%h dB=%h, expected a=%0d b=%0d dA=%h dB=%h",
                 i, wq[i].a, wq[i].b, wq[i].da, wq[i].db,
                 exp_q[i].a, exp_q[i].b, exp_q[i].da, exp_q[i].db);
      end
    end
    if (acc_cyc.size() > 4) begin
      checks++;
      if (acc_cyc[4] - acc_cyc[3] < 3) begin
        fails++;
        $display("FAIL b2b_gap: accept spacing %0d, expected at least 3",
                 acc_cyc[4] - acc_cyc[3]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc           = 0;
    checks        = 0;
    fails         = 0;
    wf_prev       = 1'b1;
    rstn          = 1'b0;
    bus.length    = 7'd16;
    bus.in_valid  = 1'b0;
    bus.in_dA     = '0;
    bus.in_dB     = '0;
    bus.in_last   = 1'b0;
    bus.fifo_full = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_full_stall();
    test_toggle_valid();
    test_bad_last();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
